// File: rtl/gain_select_framer.sv
// Pairs delayed high/low-gain sample words with TRIGGER, wraps each trigger window
// into a header/data/footer frame and streams frames out of a FWFT FIFO.
module gain_select_framer #(
    parameter int DATA_DELAY      = 2,
    parameter int MAX_FRAME_WORDS = 64,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         STOP,
    input  logic [7:0]   CHANNEL_ID,
    input  logic [127:0] S_AXIS_HG_TDATA,
    input  logic [127:0] S_AXIS_LG_TDATA,
    input  logic         TRIGGER,
    input  logic         SATURATION_FLAG,
    output logic [127:0] M_AXIS_TDATA,
    output logic         M_AXIS_TVALID,
    input  logic         M_AXIS_TREADY,
    output logic         M_AXIS_TLAST,
    output logic [15:0]  DROPPED_FRAME_COUNT
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, DROP, WAIT_LOW} state_t;

    function automatic logic [127:0] make_header(input logic [7:0] ch, input logic [47:0] ts);
        return {8'hAA, ch, ts, 64'h0};
    endfunction

    function automatic logic [127:0] make_footer(input logic [7:0] ch, input logic [15:0] cnt,
                                                 input logic [15:0] idx, input logic ovf,
                                                 input logic trunc, input logic lg);
        return {8'h55, ch, cnt, idx, 77'h0, ovf, trunc, lg};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [127:0] hg_dly;
    logic [127:0] lg_dly;

    generate
        if (DATA_DELAY == 0) begin : g_nodly
            assign hg_dly = S_AXIS_HG_TDATA;
            assign lg_dly = S_AXIS_LG_TDATA;
        end else begin : g_dly
            logic [127:0] hg_sr [DATA_DELAY];
            logic [127:0] lg_sr [DATA_DELAY];
            always_ff @(posedge ACLK) begin
                hg_sr[0] <= S_AXIS_HG_TDATA;
                lg_sr[0] <= S_AXIS_LG_TDATA;
                for (int i = 1; i < DATA_DELAY; i++) begin
                    hg_sr[i] <= hg_sr[i-1];
                    lg_sr[i] <= lg_sr[i-1];
                end
            end
            assign hg_dly = hg_sr[DATA_DELAY-1];
            assign lg_dly = lg_sr[DATA_DELAY-1];
        end
    endgenerate

    // Stage p0: gain-selected word for the cycle TRIGGER was sampled
    logic [127:0] w_p0;
    logic         sat_p0;
    always_ff @(posedge ACLK) begin
        w_p0   <= SATURATION_FLAG ? lg_dly : hg_dly;
        sat_p0 <= SATURATION_FLAG;
    end

    state_t       state;
    logic [47:0]  ts;
    logic         trig_p0;
    logic         fw_en;
    logic         fw_last;
    logic [127:0] fw_data;
    logic [15:0]  word_cnt;
    logic [15:0]  lg_idx;
    logic         any_lg;
    logic [15:0]  dropped_cnt;

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  occ;
    logic [AW:0]  occ_next;
    logic         m_valid;
    logic         rd;
    logic         full;
    logic         wr_fire;
    logic         room2;
    logic         rise;

    assign occ      = wr_ptr - rd_ptr;
    assign m_valid  = (wr_ptr != rd_ptr);
    assign rd       = m_valid && M_AXIS_TREADY;
    assign full     = (occ == (AW+1)'(FIFO_DEPTH));
    assign wr_fire  = fw_en && (!full || rd);
    // Occupancy seen by the write this decision schedules for the next cycle
    assign occ_next = occ + {{AW{1'b0}}, fw_en} - {{AW{1'b0}}, rd};
    assign room2    = (occ_next <= (AW+1)'(FIFO_DEPTH - 2));
    assign rise     = TRIGGER && !trig_p0;

    // Stage p1: frame FSM, registered FIFO write request
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= IDLE;
            ts          <= 48'd0;
            trig_p0     <= 1'b1;
            fw_en       <= 1'b0;
            fw_last     <= 1'b0;
            fw_data     <= 128'h0;
            word_cnt    <= 16'd0;
            lg_idx      <= 16'hFFFF;
            any_lg      <= 1'b0;
            dropped_cnt <= 16'd0;
        end else begin
            fw_en   <= 1'b0;
            fw_last <= 1'b0;
            ts      <= ts + 48'd1;
            trig_p0 <= TRIGGER;
            if (state != IDLE && rise)
                dropped_cnt <= sat_inc(dropped_cnt);
            case (state)
                IDLE: begin
                    if (rise) begin
                        if (STOP) begin
                            state <= WAIT_LOW;
                        end else if (room2) begin
                            fw_en    <= 1'b1;
                            fw_data  <= make_header(CHANNEL_ID, ts);
                            word_cnt <= 16'd0;
                            lg_idx   <= 16'hFFFF;
                            any_lg   <= 1'b0;
                            state    <= DATA;
                        end else begin
                            dropped_cnt <= sat_inc(dropped_cnt);
                            state       <= WAIT_LOW;
                        end
                    end
                end
                DATA: begin
                    if (!trig_p0) begin
                        fw_en   <= 1'b1;
                        fw_last <= 1'b1;
                        fw_data <= make_footer(CHANNEL_ID, word_cnt, lg_idx, 1'b0, 1'b0, any_lg);
                        state   <= IDLE;
                    end else if (word_cnt == 16'(MAX_FRAME_WORDS)) begin
                        fw_en   <= 1'b1;
                        fw_last <= 1'b1;
                        fw_data <= make_footer(CHANNEL_ID, word_cnt, lg_idx, 1'b0, 1'b1, any_lg);
                        state   <= WAIT_LOW;
                    end else if (room2) begin
                        fw_en    <= 1'b1;
                        fw_data  <= w_p0;
                        word_cnt <= word_cnt + 16'd1;
                        if (sat_p0 && !any_lg)
                            lg_idx <= word_cnt;
                        any_lg   <= any_lg | sat_p0;
                    end else begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    // The slot held back during DATA guarantees the footer fits
                    if (!trig_p0) begin
                        fw_en   <= 1'b1;
                        fw_last <= 1'b1;
                        fw_data <= make_footer(CHANNEL_ID, word_cnt, lg_idx, 1'b1, 1'b0, any_lg);
                        state   <= IDLE;
                    end
                end
                WAIT_LOW: begin
                    if (!TRIGGER)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [128:0] mem [FIFO_DEPTH];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (wr_fire)
            mem[wr_ptr[AW-1:0]] <= {fw_last, fw_data};
    end

    assign M_AXIS_TVALID = m_valid;
    assign {M_AXIS_TLAST, M_AXIS_TDATA} = m_valid ? mem[rd_ptr[AW-1:0]] : 129'h0;
    assign DROPPED_FRAME_COUNT = dropped_cnt;

endmodule

// File: tb/tb_gain_select_framer.sv
// Directed and randomized frame traffic against a window-level reference of the framer.
module tb_gain_select_framer;

    localparam int D    = 2;
    localparam int MAXW = 8;
    localparam int FD   = 8;

    logic         ACLK = 1'b0;
    logic         ARESETN = 1'b0;
    logic         STOP = 1'b0;
    logic [7:0]   CH = 8'h3C;
    logic [127:0] HG = '0;
    logic [127:0] LG = '0;
    logic         TRIGGER = 1'b0;
    logic         SAT = 1'b0;
    logic [127:0] TDATA;
    logic         TVALID;
    logic         TREADY = 1'b1;
    logic         TLAST;
    logic [15:0]  DROPPED;

    always #5 ACLK = ~ACLK;

    gain_select_framer #(.DATA_DELAY(D), .MAX_FRAME_WORDS(MAXW), .FIFO_DEPTH(FD)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .STOP(STOP), .CHANNEL_ID(CH),
        .S_AXIS_HG_TDATA(HG), .S_AXIS_LG_TDATA(LG), .TRIGGER(TRIGGER),
        .SATURATION_FLAG(SAT), .M_AXIS_TDATA(TDATA), .M_AXIS_TVALID(TVALID),
        .M_AXIS_TREADY(TREADY), .M_AXIS_TLAST(TLAST), .DROPPED_FRAME_COUNT(DROPPED)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rdy_mode = 0;

    logic [127:0] hg_h [4096];
    logic [127:0] lg_h [4096];
    bit           sat_h [4096];
    logic [128:0] exp_q [$];
    logic [128:0] got_q [$];

    task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic         stall_prev = 1'b0;
    logic [128:0] beat_prev;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("hold", {TVALID, TLAST, TDATA}, {1'b1, beat_prev});
            if (TVALID && TREADY)
                got_q.push_back({TLAST, TDATA});
            stall_prev = TVALID && !TREADY;
            beat_prev  = {TLAST, TDATA};
        end
    end

    task automatic drive(input bit trig, input bit sat, input bit stop);
        HG = {$urandom(), $urandom(), $urandom(), $urandom()};
        LG = {$urandom(), $urandom(), $urandom(), $urandom()};
        TRIGGER = trig;
        SAT = sat;
        STOP = stop;
        case (rdy_mode)
            0:       TREADY = 1'b1;
            1:       TREADY = ($urandom_range(0, 3) != 0);
            default: TREADY = 1'b0;
        endcase
        hg_h[cyc]  = HG;
        lg_h[cyc]  = LG;
        sat_h[cyc] = sat;
        @(posedge ACLK);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    // Frame for a trigger window of len cycles starting at t0; cap = data words that fit
    function automatic void expect_frame(input int t0, input int len, input int cap);
        int n;
        bit ovf, trunc, any;
        logic [15:0] idx;
        logic [127:0] w;
        ovf = 0; trunc = 0; any = 0; idx = 16'hFFFF;
        if (len > cap && cap < MAXW) begin
            n = cap; ovf = 1;
        end else if (len > MAXW) begin
            n = MAXW; trunc = 1;
        end else begin
            n = len;
        end
        exp_q.push_back({1'b0, 8'hAA, CH, 48'(t0), 64'h0});
        for (int i = 0; i < n; i++) begin
            w = sat_h[t0+i] ? lg_h[t0+i-D] : hg_h[t0+i-D];
            if (sat_h[t0+i] && !any)
                idx = 16'(i);
            any = any | sat_h[t0+i];
            exp_q.push_back({1'b0, w});
        end
        exp_q.push_back({1'b1, 8'h55, CH, 16'(n), idx, 77'h0, ovf, trunc, any});
    endfunction

    task automatic compare(input string tag);
        int waited;
        logic [128:0] g;
        waited = 0;
        while (got_q.size() < exp_q.size() && waited < 300) begin
            idle(1);
            waited++;
        end
        idle(3);
        chk({tag, "_beats"}, 130'(got_q.size()), 130'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : '0;
            chk($sformatf("%s[%0d]", tag, i), {1'b0, g}, {1'b0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int t0;
        int len;

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_tvalid", 130'(TVALID), 130'(0));
        chk("rst_tlast", 130'(TLAST), 130'(0));
        chk("rst_tdata", 130'(TDATA), 130'(0));
        chk("rst_dropped", 130'(DROPPED), 130'(0));
        ARESETN = 1'b1;
        cyc = 0;

        while (cyc < 10) drive(1'b0, 1'b0, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 1'b0);
        expect_frame(10, 4, 1000);
        compare("basic");

        t0 = cyc;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        expect_frame(t0, 5, 1000);
        compare("satsel");

        rdy_mode = 1;
        for (int f = 0; f < 20; f++) begin
            idle($urandom_range(0, 4));
            len = $urandom_range(1, 5);
            t0 = cyc;
            for (int k = 0; k < len; k++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            expect_frame(t0, len, 1000);
            compare($sformatf("rand%0d", f));
        end
        rdy_mode = 0;

        t0 = cyc;
        repeat (12) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        expect_frame(t0, 12, 1000);
        compare("trunc");
        t0 = cyc;
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        expect_frame(t0, 3, 1000);
        compare("after_trunc");
        chk("dropped_zero", 130'(DROPPED), 130'(0));

        rdy_mode = 2;
        idle(2);
        t0 = cyc;
        repeat (10) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        expect_frame(t0, 10, FD - 2);
        idle(3);
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        idle(3);
        chk("dropped_full", 130'(DROPPED), 130'(1));
        chk("full_no_beats", 130'(got_q.size()), 130'(0));
        rdy_mode = 0;
        compare("overflow");

        repeat (3) drive(1'b1, 1'b0, 1'b1);
        idle(2);
        compare("stop_edge");
        chk("stop_dropped", 130'(DROPPED), 130'(1));
        t0 = cyc;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        expect_frame(t0, 5, 1000);
        compare("stop_mid");

        repeat (3) drive(1'b1, 1'b0, 1'b0);
        ARESETN = 1'b0;
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        chk("mid_rst_tvalid", 130'(TVALID), 130'(0));
        chk("mid_rst_tlast", 130'(TLAST), 130'(0));
        chk("mid_rst_tdata", 130'(TDATA), 130'(0));
        chk("mid_rst_dropped", 130'(DROPPED), 130'(0));
        ARESETN = 1'b1;
        cyc = 0;
        got_q.delete();
        exp_q.delete();
        repeat (5) drive(1'b1, 1'b0, 1'b0);
        idle(3);
        chk("rst_no_beats", 130'(got_q.size()), 130'(0));
        t0 = cyc;
        repeat (3) drive(1'b1, 1'b1, 1'b0);
        expect_frame(t0, 3, 1000);
        compare("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
